// File: rtl/shift_frame_pkg.sv
// shift_frame_pkg: shared state encoding and line constants for the shift-frame receiver.
package shift_frame_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;
   localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/shift_frame_shifter.sv
// shift_frame_shifter: WIDTH-bit serial-in shift register with enable, clear and direction select.
module shift_frame_shifter #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic             din,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         q <= '0;
      else if (clr)
         q <= '0;
      else if (en)
         q <= MSB_FIRST ? {q[WIDTH-2:0], din} : {din, q[WIDTH-1:1]};
   end
endmodule

// File: rtl/shift_frame_receiver.sv
// shift_frame_receiver: start/data/stop frame receiver with a one-entry valid/ready output buffer.
// Define PARITY_CHECK_EN to add an even-parity bit after the data and a parity_error pulse.
module shift_frame_receiver
   import shift_frame_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             serial_in,
   input  logic             serial_valid,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             framing_error,
   output logic             overrun,
`ifdef PARITY_CHECK_EN
   output logic             parity_error,
`endif
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   state_t state, state_next;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] word;
   logic last_bit, stop_fire, good, load;
   assign last_bit  = cnt == CW'(WIDTH - 1);
   assign stop_fire = serial_valid && state == ST_STOP;
   assign busy      = state != ST_IDLE;
   shift_frame_shifter #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shifter (
      .clk  (clk),
      .reset(reset),
      .en   (serial_valid && state == ST_DATA),
      .clr  (state == ST_IDLE),
      .din  (serial_in),
      .q    (word)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_next;
   end
   always_comb begin
      state_next = state;
      if (serial_valid)
         unique case (state)
            ST_IDLE:   state_next = serial_in != LINE_IDLE ? ST_DATA : ST_IDLE;
`ifdef PARITY_CHECK_EN
            ST_DATA:   state_next = last_bit ? ST_PARITY : ST_DATA;
`else
            ST_DATA:   state_next = last_bit ? ST_STOP : ST_DATA;
`endif
            ST_PARITY: state_next = ST_STOP;
            ST_STOP:   state_next = ST_IDLE;
         endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (state != ST_DATA)
         cnt <= '0;
      else if (serial_valid)
         cnt <= cnt + 1'b1;
   end
`ifdef PARITY_CHECK_EN
   // par ends up 1 in STOP exactly when data plus parity bit hold an odd number of ones
   logic par;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         par <= 1'b0;
      else if (state == ST_IDLE)
         par <= 1'b0;
      else if (serial_valid && (state == ST_DATA || state == ST_PARITY))
         par <= par ^ serial_in;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         parity_error <= 1'b0;
      else
         parity_error <= stop_fire && par;
   end
   assign good = serial_in && !par;
`else
   assign good = serial_in;
`endif
   assign load = stop_fire && good && (!out_valid || out_ready);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out      <= '0;
         out_valid     <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         data_out      <= load ? word : data_out;
         out_valid     <= load ? 1'b1 : (out_ready ? 1'b0 : out_valid);
         framing_error <= stop_fire && !serial_in;
         overrun       <= stop_fire && good && out_valid && !out_ready;
      end
   end
endmodule

// File: tb/tb_shift_frame_receiver.sv
// tb_shift_frame_receiver: random and directed frames checked every cycle against a bit-queue model.
module tb_shift_frame_receiver;
   localparam int W = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic serial_in = 1'b1;
   logic serial_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [W-1:0] data_m, data_l;
   logic valid_m, valid_l, fe_m, fe_l, ov_m, ov_l, busy_m, busy_l;
   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   bit rnd = 1'b0;
   always #5 clk = ~clk;
   shift_frame_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
      .data_out(data_m), .out_valid(valid_m), .out_ready(out_ready),
      .framing_error(fe_m), .overrun(ov_m), .busy(busy_m)
   );
   shift_frame_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
      .data_out(data_l), .out_valid(valid_l), .out_ready(out_ready),
      .framing_error(fe_l), .overrun(ov_l), .busy(busy_l)
   );
   // model: a frame is the queue of bits after a start bit; it resolves once W data + stop are in
   bit m_active = 1'b0;
   bit bq[$];
   bit e_valid = 1'b0, e_fe = 1'b0, e_ov = 1'b0, pv = 1'b0, loaded = 1'b0;
   logic [W-1:0] e_m = '0, e_l = '0;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_active = 0; bq.delete(); e_valid = 0; e_fe = 0; e_ov = 0; e_m = '0; e_l = '0;
      end else begin
         pv = e_valid; e_fe = 0; e_ov = 0; loaded = 0;
         if (serial_valid) begin
            if (!m_active) begin
               if (!serial_in) begin m_active = 1; bq.delete(); end
            end else begin
               bq.push_back(serial_in);
               if (bq.size() == W + 1) begin
                  m_active = 0;
                  if (!bq[W]) e_fe = 1;
                  else if (pv && !out_ready) e_ov = 1;
                  else begin
                     for (int i = 0; i < W; i++) begin e_m[W-1-i] = bq[i]; e_l[i] = bq[i]; end
                     e_valid = 1; loaded = 1;
                  end
               end
            end
         end
         if (!loaded && pv && out_ready) e_valid = 0;
      end
   end
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask
   always @(negedge clk) if (chk_en) begin
      check("busy_m", 32'(busy_m), 32'(m_active));
      check("busy_l", 32'(busy_l), 32'(m_active));
      check("valid_m", 32'(valid_m), 32'(e_valid));
      check("valid_l", 32'(valid_l), 32'(e_valid));
      check("data_m", 32'(data_m), 32'(e_m));
      check("data_l", 32'(data_l), 32'(e_l));
      check("fe_m", 32'(fe_m), 32'(e_fe));
      check("fe_l", 32'(fe_l), 32'(e_fe));
      check("ov_m", 32'(ov_m), 32'(e_ov));
      check("ov_l", 32'(ov_l), 32'(e_ov));
   end
   task automatic tick();
      @(negedge clk);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
   endtask
   task automatic send_bit(input logic b, input int gap);
      serial_valid = 1'b1; serial_in = b;
      tick();
      serial_valid = 1'b0; serial_in = 1'b1;
      repeat (gap) tick();
   endtask
   task automatic send_frame(input logic [W-1:0] d, input logic stop, input int gap);
      send_bit(1'b0, gap);
      for (int i = W - 1; i >= 0; i--) send_bit(d[i], gap);
      send_bit(stop, gap);
   endtask
   initial begin
      #1 reset = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      serial_valid = 1'b1; serial_in = 1'b1;
      repeat (5) tick();
      check("idle_busy", 32'(busy_m), 0);
      check("idle_valid", 32'(valid_m), 0);
      serial_valid = 1'b0;
      out_ready = 1'b1;
      send_frame(4'b1101, 1'b1, 0);
      check("f1_valid", 32'(valid_m), 1);
      check("f1_data_m", 32'(data_m), 32'b1101);
      check("f1_data_l", 32'(data_l), 32'b1011);
      tick();
      check("f1_valid_fall", 32'(valid_m), 0);
      send_bit(1'b0, 3);
      check("gap_busy", 32'(busy_m), 1);
      send_bit(1'b1, 3); send_bit(1'b1, 3); send_bit(1'b0, 3); send_bit(1'b1, 3);
      check("gap_busy2", 32'(busy_m), 1);
      send_bit(1'b1, 0);
      check("gap_data", 32'(data_m), 32'b1101);
      check("gap_valid", 32'(valid_m), 1);
      send_frame(4'b1010, 1'b0, 0);
      check("fe_pulse", 32'(fe_m), 1);
      check("fe_valid", 32'(valid_m), 0);
      tick();
      check("fe_fall", 32'(fe_m), 0);
      out_ready = 1'b0;
      send_frame(4'b1101, 1'b1, 0);
      send_frame(4'b0011, 1'b1, 0);
      check("ov_pulse", 32'(ov_m), 1);
      check("ov_keep", 32'(data_m), 32'b1101);
      tick();
      check("ov_fall", 32'(ov_m), 0);
      send_bit(1'b0, 0);
      send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
      out_ready = 1'b1;
      send_bit(1'b1, 0);
      check("same_edge_valid", 32'(valid_m), 1);
      check("same_edge_data", 32'(data_m), 32'b0011);
      check("same_edge_ov", 32'(ov_m), 0);
      out_ready = 1'b0;
      send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      #2 reset = 1'b0;
      #1;
      check("rst_valid", 32'(valid_m), 0);
      check("rst_data", 32'(data_m), 0);
      check("rst_busy", 32'(busy_m), 0);
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      send_frame(4'b0110, 1'b1, 0);
      check("post_rst_data", 32'(data_m), 32'b0110);
      check("post_rst_valid", 32'(valid_m), 1);
      rnd = 1'b1;
      repeat (200) begin
         repeat ($urandom_range(0, 2)) send_bit(1'b1, $urandom_range(0, 1));
         send_frame(W'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 2));
      end
      rnd = 1'b0;
      repeat (3) tick();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
